// File: rtl/bin_gray_counter.sv
// Up/down binary counter with a registered Gray-coded twin, sequenced by start/stop and handed out over valid/ready.
// Optional macro GRAY_STEP_CHECK_EN adds a sticky err output that flags non-single-bit Gray steps between transfers.
module bin_gray_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             tc,
    output logic             busy
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic             err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SAT  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] load_clamped;
    logic             transfer;
    logic             at_boundary;

    assign transfer     = (state == RUN) && out_ready;
    assign at_boundary  = dir ? (bin_out == MAX_VAL) : (bin_out == '0);
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Gray code is derived from the next binary value so both outputs update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin_out  <= '0;
            gray_out <= '0;
        end else begin
            state    <= state_next;
            bin_out  <= count_next;
            gray_out <= count_next ^ (count_next >> 1);
        end
    end

    always_comb begin
        state_next = state;
        count_next = bin_out;
        if (stop) begin
            state_next = IDLE;
        end else if (load) begin
            count_next = load_clamped;
            if (state == SAT) begin
                state_next = RUN;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (transfer) begin
                        if (at_boundary) begin
                            if (mode) begin
                                state_next = SAT;
                            end else begin
                                count_next = dir ? '0 : MAX_VAL;
                            end
                        end else begin
                            count_next = dir ? (bin_out + WIDTH'(1)) : (bin_out - WIDTH'(1));
                        end
                    end
                end
                SAT: begin
                    if (start) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = (state == RUN);
        busy      = (state == RUN);
        tc        = transfer && at_boundary;
    end

`ifdef GRAY_STEP_CHECK_EN
    localparam bit FULL_RANGE = (MAX_COUNT == (1 << WIDTH) - 1);

    logic [WIDTH-1:0] last_gray;
    logic [WIDTH-1:0] gray_diff;
    logic             check_armed;
    logic             one_bit_step;

    assign gray_diff    = gray_out ^ last_gray;
    assign one_bit_step = (gray_diff != '0) && ((gray_diff & (gray_diff - WIDTH'(1))) == '0);

    // A load, a fresh start from IDLE, or a short-range wrap breaks the single-bit chain, so the next step is not judged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err         <= 1'b0;
            last_gray   <= '0;
            check_armed <= 1'b0;
        end else begin
            if (transfer) begin
                if (check_armed && !one_bit_step) begin
                    err <= 1'b1;
                end
                last_gray   <= gray_out;
                check_armed <= !(at_boundary && !mode && !FULL_RANGE);
            end
            if (load || state == IDLE) begin
                check_armed <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bin_gray_counter.sv
// Self-checking bench for bin_gray_counter: directed vector table, hand-written corner sequences and a randomized run.
// Two instances share stimulus: a full-range counter (MAX 15) and a short-range one (MAX 9).
module tb_bin_gray_counter;

    localparam int W      = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_SAT  = 2;

    typedef struct {
        logic         start;
        logic         stop;
        logic         dir;
        logic         mode;
        logic         load;
        logic [W-1:0] load_val;
        logic         ready;
        logic [W-1:0] exp_bin;
        logic [W-1:0] exp_gray;
        logic         exp_valid;
        logic         exp_tc;
        logic         exp_busy;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, stop, dir, mode, load, out_ready;
    logic [W-1:0] load_val;
    logic [W-1:0] bin_a, gray_a, bin_b, gray_b;
    logic         valid_a, tc_a, busy_a, valid_b, tc_b, busy_b;
`ifdef GRAY_STEP_CHECK_EN
    logic         err_a, err_b;
`endif

    int num_checks = 0;
    int num_pass   = 0;
    int m_state[2];
    int m_cnt[2];
    int m_max[2] = '{15, 9};

    always #5 clk = ~clk;

    bin_gray_counter #(.WIDTH(W), .MAX_COUNT(15)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir), .mode(mode),
        .load(load), .load_val(load_val), .bin_out(bin_a), .gray_out(gray_a),
        .out_valid(valid_a), .out_ready(out_ready), .tc(tc_a), .busy(busy_a)
`ifdef GRAY_STEP_CHECK_EN
        , .err(err_a)
`endif
    );

    bin_gray_counter #(.WIDTH(W), .MAX_COUNT(9)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir), .mode(mode),
        .load(load), .load_val(load_val), .bin_out(bin_b), .gray_out(gray_b),
        .out_valid(valid_b), .out_ready(out_ready), .tc(tc_b), .busy(busy_b)
`ifdef GRAY_STEP_CHECK_EN
        , .err(err_b)
`endif
    );

    function automatic vec_t mk(input logic st, input logic sp, input logic d, input logic md,
                                input logic ld, input int lv, input logic rdy, input int eb,
                                input int eg, input logic ev, input logic et, input logic ebz);
        vec_t v;
        v.start = st; v.stop = sp; v.dir = d; v.mode = md; v.load = ld;
        v.load_val = W'(lv); v.ready = rdy;
        v.exp_bin = W'(eb); v.exp_gray = W'(eg);
        v.exp_valid = ev; v.exp_tc = et; v.exp_busy = ebz;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        start     = v.start;
        stop      = v.stop;
        dir       = v.dir;
        mode      = v.mode;
        load      = v.load;
        load_val  = v.load_val;
        out_ready = v.ready;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        num_checks++;
        if (actual == expected) begin
            num_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d] = M_IDLE;
            m_cnt[d]   = 0;
        end
    endtask

    // Expected outputs follow from the counting rules: valid only while running, tc on hand-off of the boundary value.
    task automatic model_check(input string tag);
        for (int d = 0; d < 2; d++) begin
            int  bnd;
            bit  ev, et;
            bnd = dir ? m_max[d] : 0;
            ev  = (m_state[d] == M_RUN);
            et  = ev && out_ready && (m_cnt[d] == bnd);
            check_output($sformatf("%s.%s.bin",   tag, d ? "b" : "a"), d ? int'(bin_b)   : int'(bin_a),   m_cnt[d]);
            check_output($sformatf("%s.%s.gray",  tag, d ? "b" : "a"), d ? int'(gray_b)  : int'(gray_a),  m_cnt[d] ^ (m_cnt[d] / 2));
            check_output($sformatf("%s.%s.valid", tag, d ? "b" : "a"), d ? int'(valid_b) : int'(valid_a), int'(ev));
            check_output($sformatf("%s.%s.tc",    tag, d ? "b" : "a"), d ? int'(tc_b)    : int'(tc_a),    int'(et));
            check_output($sformatf("%s.%s.busy",  tag, d ? "b" : "a"), d ? int'(busy_b)  : int'(busy_a),  int'(ev));
        end
    endtask

    task automatic model_advance();
        for (int d = 0; d < 2; d++) begin
            int bnd;
            bit xfer;
            bnd  = dir ? m_max[d] : 0;
            xfer = (m_state[d] == M_RUN) && out_ready;
            if (stop) begin
                m_state[d] = M_IDLE;
            end else if (load) begin
                m_cnt[d] = (int'(load_val) > m_max[d]) ? m_max[d] : int'(load_val);
                if (m_state[d] == M_SAT) m_state[d] = M_RUN;
            end else if (m_state[d] != M_RUN) begin
                if (start) m_state[d] = M_RUN;
            end else if (xfer) begin
                if (m_cnt[d] == bnd && mode) m_state[d] = M_SAT;
                else if (dir) m_cnt[d] = (m_cnt[d] + 1) % (m_max[d] + 1);
                else m_cnt[d] = (m_cnt[d] + m_max[d]) % (m_max[d] + 1);
            end
        end
    endtask

    task automatic cycle(input vec_t v, input bit use_table, input string tag);
        @(negedge clk);
        apply_stimulus(v);
        #1;
        model_check(tag);
        if (use_table) begin
            check_output({tag, ".tbl.bin"},   int'(bin_a),   int'(v.exp_bin));
            check_output({tag, ".tbl.gray"},  int'(gray_a),  int'(v.exp_gray));
            check_output({tag, ".tbl.valid"}, int'(valid_a), int'(v.exp_valid));
            check_output({tag, ".tbl.tc"},    int'(tc_a),    int'(v.exp_tc));
            check_output({tag, ".tbl.busy"},  int'(busy_a),  int'(v.exp_busy));
        end
        model_advance();
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, ".bin"},   int'(bin_a),   0);
        check_output({tag, ".gray"},  int'(gray_a),  0);
        check_output({tag, ".valid"}, int'(valid_a), 0);
        check_output({tag, ".tc"},    int'(tc_a),    0);
        check_output({tag, ".busy"},  int'(busy_a),  0);
        check_output({tag, ".b_bin"}, int'(bin_b),   0);
`ifdef GRAY_STEP_CHECK_EN
        check_output({tag, ".err"},   int'(err_a),   0);
`endif
    endtask

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   gray_seq[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
        int   scen1_len;

        // Up count with wrap: 0..15 then back to 0, tc only on the hand-off of 15.
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, i, gray_seq[i], 1, (i == 15), 1));
        end
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 0, 1));
        scen1_len = vecs.size();
        // Saturating down count from a loaded 3.
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 1, 3, 2, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 3, 2, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 2, 3, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        // Back-pressure: ready 1,0,0,1 yields exactly two increments.
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 2, 3, 1, 0, 1));
        // stop + load + transfer at count 5: stop wins, count held, restart presents 5.
        vecs.push_back(mk(0, 0, 1, 0, 1, 5, 0, 2, 3, 1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 9, 1, 5, 7, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 5, 7, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 5, 7, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 5, 7, 1, 0, 1));

        rst_n = 1'b0;
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #12;
        check_all_zero("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i], 1'b1, $sformatf("vec%0d", i));
`ifdef GRAY_STEP_CHECK_EN
            if (i < scen1_len) begin
                check_output($sformatf("vec%0d.err_a", i), int'(err_a), 0);
                check_output($sformatf("vec%0d.err_b", i), int'(err_b), 0);
            end
`endif
        end

        // Asynchronous reset between edges while running at 7.
        cycle(mk(0, 0, 1, 0, 1, 7, 0, 0, 0, 0, 0, 0), 1'b0, "pre_rst_load");
        cycle(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "pre_rst_hold");
        check_output("pre_rst.bin", int'(bin_a), 7);
        #2;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        apply_stimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // Clamped load on the MAX 9 instance, then an up-transfer wraps with tc.
        cycle(mk(0, 0, 1, 0, 1, 12, 0, 0, 0, 0, 0, 0), 1'b0, "clamp_load");
        cycle(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "clamp_start");
        check_output("clamp.b.bin",   int'(bin_b),   9);
        check_output("clamp.b.gray",  int'(gray_b),  13);
        check_output("clamp.a.bin",   int'(bin_a),   12);
        cycle(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0, "clamp_xfer");
        check_output("clamp.b.tc",    int'(tc_b),    1);
        check_output("clamp.a.tc",    int'(tc_a),    0);
        cycle(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0), 1'b0, "clamp_wrap");
        check_output("wrap.b.bin",    int'(bin_b),   0);
        check_output("wrap.b.tc",     int'(tc_b),    0);
        check_output("wrap.a.bin",    int'(bin_a),   13);

        // Randomized traffic against the model for both instances.
        v = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            v.start    = ($urandom_range(0, 3) == 0);
            v.stop     = ($urandom_range(0, 39) == 0);
            v.load     = ($urandom_range(0, 19) == 0);
            v.load_val = W'($urandom_range(0, 15));
            v.ready    = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) v.dir  = ~v.dir;
            if ($urandom_range(0, 31) == 0) v.mode = ~v.mode;
            cycle(v, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule
